// File: rtl/serial_write_buffer.sv
// serial_write_buffer: captures a word on start and shifts it out MSB-first, one bit per write_sig strobe.
module serial_write_buffer #(
  parameter int   BUF_SIZE   = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUF_SIZE-1:0] data_in,
  input  logic                write_sig,
  output logic                data_out,
  output logic                done_sig
);
  localparam int CW = $clog2(BUF_SIZE + 1);
  typedef enum logic [1:0] {RESET, IDLE, WRITE} state_t;
  state_t              state, state_n;
  logic [BUF_SIZE-1:0] shreg, shreg_n;
  logic [CW-1:0]       ctr, ctr_n;
  logic                data_n, done_n;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state    <= RESET;
      shreg    <= '0;
      ctr      <= '0;
      data_out <= IDLE_LEVEL;
      done_sig <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      ctr      <= ctr_n;
      data_out <= data_n;
      done_sig <= done_n;
    end
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    ctr_n   = ctr;
    data_n  = data_out;
    done_n  = done_sig;
    case (state)
      RESET: begin
        state_n = IDLE;
        shreg_n = '0;
        ctr_n   = '0;
        data_n  = IDLE_LEVEL;
        done_n  = 1'b1;
      end
      IDLE: if (start) begin
        state_n = WRITE;
        shreg_n = data_in;
        ctr_n   = '0;
        data_n  = data_in[BUF_SIZE-1];
        done_n  = 1'b0;
      end
      WRITE: if (write_sig) begin
        if (ctr == CW'(BUF_SIZE - 1)) begin
          state_n = IDLE;
          ctr_n   = CW'(BUF_SIZE);
          data_n  = IDLE_LEVEL;
          done_n  = 1'b1;
        end else begin
          shreg_n = {shreg[BUF_SIZE-2:0], 1'b0};
          ctr_n   = ctr + 1'b1;
          data_n  = shreg[BUF_SIZE-2];
        end
      end
      default: begin
        state_n = RESET;
        done_n  = 1'b0;
      end
    endcase
  end
endmodule
